// File: rtl/dyt_mem_arbiter_pkg.sv
// Shared types for the SRAM arbiter: machine word, arbiter FSM states and
// the identity of the requester currently owning the SRAM.
package dyt_mem_arbiter_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } arb_state_t;

    typedef enum logic {
        INST,
        DATA
    } mem_owner_t;

endpackage

// File: rtl/dyt_sram_if.sv
// Bus between the single SRAM master (the arbiter) and the SRAM itself.
interface dyt_sram_if;
    import dyt_mem_arbiter_pkg::*;

    word_t sram_address;
    word_t sram_w_data;
    word_t sram_r_data;
    logic  sram_ren;
    logic  sram_wen;

    modport cpu (
        output sram_address,
        output sram_w_data,
        output sram_ren,
        output sram_wen,
        input  sram_r_data
    );

    modport sram (
        input  sram_address,
        input  sram_w_data,
        input  sram_ren,
        input  sram_wen,
        output sram_r_data
    );
endinterface

// File: rtl/dyt_mem_arbiter.sv
// Arbitrates the single-ported SRAM between instruction fetch and data memory:
// latch the winner, hold the SRAM enables for SRAM_LAT cycles, then pulse a hit.
module dyt_mem_arbiter
    import dyt_mem_arbiter_pkg::*;
#(
    parameter int SRAM_LAT = 2
) (
    input  logic  CLK,
    input  logic  nRST,
    input  logic  iren,
    input  word_t iaddr,
    output logic  ihit,
    output word_t iload,
    input  logic  dren,
    input  logic  dwen,
    input  word_t daddr,
    input  word_t dstore,
    output logic  dhit,
    output word_t dload,
    dyt_sram_if.cpu sram
);

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SRAM_LAT - 1);

    arb_state_t       state_reg, state_next;
    logic [CNT_W-1:0] count_reg, count_next;
    mem_owner_t       owner_reg, owner_next;
    mem_owner_t       last_owner_reg, last_owner_next;
    word_t            addr_reg, addr_next;
    word_t            wdata_reg, wdata_next;
    logic             write_reg, write_next;
    word_t            iload_reg, iload_next;
    word_t            dload_reg, dload_next;

    logic data_req;
    logic grant_data;

    // A simultaneous read and write request is serviced as a write.
    assign data_req = dren | dwen;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg      <= IDLE;
            count_reg      <= '0;
            owner_reg      <= INST;
            last_owner_reg <= INST;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            write_reg      <= 1'b0;
            iload_reg      <= '0;
            dload_reg      <= '0;
        end else begin
            state_reg      <= state_next;
            count_reg      <= count_next;
            owner_reg      <= owner_next;
            last_owner_reg <= last_owner_next;
            addr_reg       <= addr_next;
            wdata_reg      <= wdata_next;
            write_reg      <= write_next;
            iload_reg      <= iload_next;
            dload_reg      <= dload_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        count_next      = count_reg;
        owner_next      = owner_reg;
        last_owner_next = last_owner_reg;
        addr_next       = addr_reg;
        wdata_next      = wdata_reg;
        write_next      = write_reg;
        iload_next      = iload_reg;
        dload_next      = dload_reg;
        grant_data      = 1'b0;

        unique case (state_reg)
            IDLE: begin
                if (iren || data_req) begin
                    // Data has priority unless it won last time, so a steady
                    // stream of data accesses cannot starve instruction fetch.
                    grant_data      = data_req && (!iren || (last_owner_reg != DATA));
                    owner_next      = grant_data ? DATA : INST;
                    last_owner_next = grant_data ? DATA : INST;
                    addr_next       = grant_data ? daddr : iaddr;
                    wdata_next      = grant_data ? dstore : '0;
                    write_next      = grant_data && dwen;
                    count_next      = CNT_LOAD;
                    state_next      = ACCESS;
                end
            end
            ACCESS: begin
                if (count_reg != '0) begin
                    count_next = count_reg - 1'b1;
                end else begin
                    if (!write_reg) begin
                        if (owner_reg == DATA) begin
                            dload_next = sram.sram_r_data;
                        end else begin
                            iload_next = sram.sram_r_data;
                        end
                    end
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The SRAM bus is quiet outside ACCESS; write data only appears for writes.
    assign sram.sram_address = (state_reg == ACCESS) ? addr_reg : '0;
    assign sram.sram_w_data  = ((state_reg == ACCESS) && write_reg) ? wdata_reg : '0;
    assign sram.sram_ren     = (state_reg == ACCESS) && !write_reg;
    assign sram.sram_wen     = (state_reg == ACCESS) && write_reg;

    assign ihit  = (state_reg == RESP) && (owner_reg == INST);
    assign dhit  = (state_reg == RESP) && (owner_reg == DATA);
    assign iload = iload_reg;
    assign dload = dload_reg;

endmodule

// File: tb/tb_dyt_mem_arbiter.sv
// Bench for dyt_mem_arbiter: per-cycle vector table, directed multi-cycle
// sequences, and random requesters checked against a transaction-level model.
module tb_dyt_mem_arbiter;
    import dyt_mem_arbiter_pkg::*;

    localparam int LAT = 2;

    logic  CLK;
    logic  nRST;
    logic  iren;
    word_t iaddr;
    logic  ihit;
    word_t iload;
    logic  dren;
    logic  dwen;
    word_t daddr;
    word_t dstore;
    logic  dhit;
    word_t dload;

    dyt_sram_if sif ();

    dyt_mem_arbiter #(.SRAM_LAT(LAT)) dut (
        .CLK    (CLK),
        .nRST   (nRST),
        .iren   (iren),
        .iaddr  (iaddr),
        .ihit   (ihit),
        .iload  (iload),
        .dren   (dren),
        .dwen   (dwen),
        .daddr  (daddr),
        .dstore (dstore),
        .dhit   (dhit),
        .dload  (dload),
        .sram   (sif)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Power-on content of the SRAM stand-in; word 0x40 holds 0x13.
    function automatic word_t init_word(input logic [9:0] idx);
        if (idx == 10'd16) return 32'h0000_0013;
        return {6'h30, idx, ~idx, 6'h2A};
    endfunction

    function automatic logic [9:0] widx(input word_t a);
        return a[11:2];
    endfunction

    // SRAM stand-in: one registered stage from address to read data.
    word_t mem [1024];
    bit    mem_wr [1024];
    always @(posedge CLK) begin
        if (sif.sram_wen) begin
            mem[widx(sif.sram_address)]    <= sif.sram_w_data;
            mem_wr[widx(sif.sram_address)] <= 1'b1;
        end
        sif.sram_r_data <= mem_wr[widx(sif.sram_address)] ? mem[widx(sif.sram_address)]
                                                           : init_word(widx(sif.sram_address));
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk32(input string name, input word_t act, input word_t exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic drv_pt();
        @(posedge CLK);
        #1;
    endtask

    task automatic smp_pt();
        @(negedge CLK);
    endtask

    task automatic chk_quiet(input string name);
        chk1({name, " ihit"}, ihit, 1'b0);
        chk1({name, " dhit"}, dhit, 1'b0);
        chk1({name, " ren"}, sif.sram_ren, 1'b0);
        chk1({name, " wen"}, sif.sram_wen, 1'b0);
    endtask

    typedef struct {
        logic  iren;
        word_t iaddr;
        logic  dren;
        logic  dwen;
        word_t daddr;
        word_t dstore;
        logic  e_ihit;
        logic  e_dhit;
        logic  e_ren;
        logic  e_wen;
        word_t e_addr;
        word_t e_wdata;
        word_t e_iload;
        word_t e_dload;
    } vec_t;

    vec_t vecs [20];

    function automatic vec_t mk(input logic ir, input word_t ia, input logic dr, input logic dw,
                                input word_t da, input word_t ds, input logic eih, input logic edh,
                                input logic er, input logic ew, input word_t ea, input word_t ewd,
                                input word_t eil, input word_t edl);
        vec_t v;
        v.iren = ir;  v.iaddr = ia;  v.dren = dr;  v.dwen = dw;  v.daddr = da;  v.dstore = ds;
        v.e_ihit = eih;  v.e_dhit = edh;  v.e_ren = er;  v.e_wen = ew;
        v.e_addr = ea;  v.e_wdata = ewd;  v.e_iload = eil;  v.e_dload = edl;
        return v;
    endfunction

    // Transaction-level reference model state for the random phase.
    word_t mmem [1024];
    bit    mmem_wr [1024];

    function automatic word_t model_read(input word_t a);
        return mmem_wr[widx(a)] ? mmem[widx(a)] : init_word(widx(a));
    endfunction

    initial begin
        word_t DB;
        DB = 32'hDEAD_BEEF;
        // lone fetch, lone write, read-back, read+write treated as write
        vecs[0]  = mk(1, 32'h40, 0, 0, 0, 0,                       0, 0, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(1, 32'h40, 0, 0, 0, 0,                       0, 0, 1, 0, 32'h40, 0, 0, 0);
        vecs[2]  = mk(1, 32'h40, 0, 0, 0, 0,                       0, 0, 1, 0, 32'h40, 0, 0, 0);
        vecs[3]  = mk(1, 32'h40, 0, 0, 0, 0,                       1, 0, 0, 0, 0, 0, 32'h13, 0);
        vecs[4]  = mk(0, 0, 0, 0, 0, 0,                            0, 0, 0, 0, 0, 0, 32'h13, 0);
        vecs[5]  = mk(0, 0, 0, 1, 32'h100, DB,                     0, 0, 0, 0, 0, 0, 32'h13, 0);
        vecs[6]  = mk(0, 0, 0, 1, 32'h100, DB,                     0, 0, 0, 1, 32'h100, DB, 32'h13, 0);
        vecs[7]  = mk(0, 0, 0, 1, 32'h100, DB,                     0, 0, 0, 1, 32'h100, DB, 32'h13, 0);
        vecs[8]  = mk(0, 0, 0, 1, 32'h100, DB,                     0, 1, 0, 0, 0, 0, 32'h13, 0);
        vecs[9]  = mk(0, 0, 0, 0, 0, 0,                            0, 0, 0, 0, 0, 0, 32'h13, 0);
        vecs[10] = mk(0, 0, 1, 0, 32'h100, 0,                      0, 0, 0, 0, 0, 0, 32'h13, 0);
        vecs[11] = mk(0, 0, 1, 0, 32'h100, 0,                      0, 0, 1, 0, 32'h100, 0, 32'h13, 0);
        vecs[12] = mk(0, 0, 1, 0, 32'h100, 0,                      0, 0, 1, 0, 32'h100, 0, 32'h13, 0);
        vecs[13] = mk(0, 0, 1, 0, 32'h100, 0,                      0, 1, 0, 0, 0, 0, 32'h13, DB);
        vecs[14] = mk(0, 0, 0, 0, 0, 0,                            0, 0, 0, 0, 0, 0, 32'h13, DB);
        vecs[15] = mk(0, 0, 1, 1, 32'h104, 32'h1234_5678,          0, 0, 0, 0, 0, 0, 32'h13, DB);
        vecs[16] = mk(0, 0, 1, 1, 32'h104, 32'h1234_5678,          0, 0, 0, 1, 32'h104, 32'h1234_5678, 32'h13, DB);
        vecs[17] = mk(0, 0, 1, 1, 32'h104, 32'h1234_5678,          0, 0, 0, 1, 32'h104, 32'h1234_5678, 32'h13, DB);
        vecs[18] = mk(0, 0, 1, 1, 32'h104, 32'h1234_5678,          0, 1, 0, 0, 0, 0, 32'h13, DB);
        vecs[19] = mk(0, 0, 0, 0, 0, 0,                            0, 0, 0, 0, 0, 0, 32'h13, DB);

        nRST = 1'b0;  iren = 0;  iaddr = 0;  dren = 0;  dwen = 0;  daddr = 0;  dstore = 0;
        #1;
        chk_quiet("reset");
        chk32("reset iload", iload, 0);
        chk32("reset dload", dload, 0);
        chk32("reset addr", sif.sram_address, 0);
        chk32("reset wdata", sif.sram_w_data, 0);
        drv_pt();
        drv_pt();
        nRST = 1'b1;

        // ---- table-driven cycle vectors
        for (int i = 0; i < 20; i++) begin
            drv_pt();
            iren = vecs[i].iren;  iaddr = vecs[i].iaddr;
            dren = vecs[i].dren;  dwen = vecs[i].dwen;
            daddr = vecs[i].daddr;  dstore = vecs[i].dstore;
            smp_pt();
            chk1($sformatf("vec%0d ihit", i), ihit, vecs[i].e_ihit);
            chk1($sformatf("vec%0d dhit", i), dhit, vecs[i].e_dhit);
            chk1($sformatf("vec%0d ren", i), sif.sram_ren, vecs[i].e_ren);
            chk1($sformatf("vec%0d wen", i), sif.sram_wen, vecs[i].e_wen);
            if (vecs[i].e_ren || vecs[i].e_wen)
                chk32($sformatf("vec%0d addr", i), sif.sram_address, vecs[i].e_addr);
            if (vecs[i].e_wen)
                chk32($sformatf("vec%0d wdata", i), sif.sram_w_data, vecs[i].e_wdata);
            chk32($sformatf("vec%0d iload", i), iload, vecs[i].e_iload);
            chk32($sformatf("vec%0d dload", i), dload, vecs[i].e_dload);
            if (vecs[i].e_ihit || vecs[i].e_dhit)
                $display("txn vec%0d: hit i=%b d=%b iload=%h dload=%h", i, ihit, dhit, iload, dload);
        end

        // ---- asynchronous reset mid-cycle during an access, then idle
        drv_pt();
        iren = 1;  iaddr = 32'h40;
        drv_pt();
        #2;
        nRST = 1'b0;
        iren = 0;
        #1;
        chk_quiet("async rst");
        chk32("async rst addr", sif.sram_address, 0);
        chk32("async rst iload", iload, 0);
        chk32("async rst dload", dload, 0);
        drv_pt();
        drv_pt();
        nRST = 1'b1;
        for (int c = 0; c < 5; c++) begin
            smp_pt();
            chk_quiet($sformatf("idle%0d", c));
            drv_pt();
        end
        $display("txn async reset + 5 idle cycles");

        // ---- reset pulse in cycle 2 of a read: abandoned, no hit
        iren = 1;  iaddr = 32'h40;
        drv_pt();
        drv_pt();
        nRST = 1'b0;
        iren = 0;
        #2;
        nRST = 1'b1;
        for (int c = 0; c < 4; c++) begin
            smp_pt();
            chk1($sformatf("abandon%0d ihit", c), ihit, 1'b0);
            drv_pt();
        end
        iren = 1;
        for (int c = 0; c <= LAT + 1; c++) begin
            smp_pt();
            chk1($sformatf("refetch c%0d ihit", c), ihit, c == LAT + 1);
            chk1($sformatf("refetch c%0d ren", c), sif.sram_ren, (c >= 1) && (c <= LAT));
            if (c == LAT + 1) chk32("refetch iload", iload, 32'h13);
            drv_pt();
        end
        iren = 0;
        $display("txn reset during access, refetch iload=%h", iload);

        // ---- contention with alternation (last owner INST after refetch)
        for (int c = 0; c <= 16; c++) begin
            if (c != 0) drv_pt();
            case (c)
                0:  begin iren = 1; iaddr = 32'h80; dren = 1; daddr = 32'h200; end
                4:  daddr = 32'h204;
                8:  iaddr = 32'h84;
                12: dren = 0;
                16: iren = 0;
                default: ;
            endcase
            smp_pt();
            chk1($sformatf("cont c%0d dhit", c), dhit, (c == 3) || (c == 11));
            chk1($sformatf("cont c%0d ihit", c), ihit, (c == 7) || (c == 15));
            if (c == 3)  chk32("cont dload0", dload, init_word(widx(32'h200)));
            if (c == 7)  chk32("cont iload0", iload, init_word(widx(32'h80)));
            if (c == 11) chk32("cont dload1", dload, init_word(widx(32'h204)));
            if (c == 15) chk32("cont iload1", iload, init_word(widx(32'h84)));
        end
        $display("txn contention sequence data/inst/data/inst");

        // ---- operands latched: address change during ACCESS ignored
        for (int c = 0; c <= 4; c++) begin
            drv_pt();
            case (c)
                0: begin dren = 1; daddr = 32'h200; end
                2: daddr = 32'h300;
                4: dren = 0;
                default: ;
            endcase
            smp_pt();
            if (c == 1 || c == 2) chk32($sformatf("latch c%0d addr", c), sif.sram_address, 32'h200);
            if (c == 3) begin
                chk1("latch dhit", dhit, 1'b1);
                chk32("latch dload", dload, init_word(widx(32'h200)));
            end
        end
        $display("txn mid-access address change");

        // ---- random requesters against a transaction-level model
        drv_pt();
        nRST = 1'b0;  iren = 0;  dren = 0;  dwen = 0;
        drv_pt();
        nRST = 1'b1;
        begin
            int    grant_at, hit_at, free_at, k;
            bit    own_data, wr, last_data, i_drop, d_drop, in_acc;
            word_t g_addr, g_wdata, pend_load, exp_il, exp_dl;
            grant_at = -100;  hit_at = -100;  free_at = 0;
            own_data = 0;  wr = 0;  last_data = 0;  i_drop = 0;  d_drop = 0;
            g_addr = 0;  g_wdata = 0;  pend_load = 0;  exp_il = 0;  exp_dl = 0;
            for (int t = 0; t < 400; t++) begin
                drv_pt();
                if (i_drop) begin
                    iren = 0;  i_drop = 0;
                end else if (!iren && $urandom_range(0, 2) == 0) begin
                    iren = 1;  iaddr = 32'h800 + $urandom_range(0, 2047);
                end
                if (d_drop) begin
                    dren = 0;  dwen = 0;  d_drop = 0;
                end else if (!dren && !dwen && $urandom_range(0, 2) == 0) begin
                    k = int'($urandom_range(0, 3));
                    dren = (k != 2);  dwen = (k >= 2);
                    daddr = 32'h800 + $urandom_range(0, 2047);
                    dstore = $urandom();
                end
                smp_pt();
                if (t == hit_at) begin
                    if (own_data) begin
                        if (!wr) exp_dl = pend_load;
                        d_drop = 1;
                    end else begin
                        exp_il = pend_load;
                        i_drop = 1;
                    end
                    $display("txn rand t=%0d %s %s addr=%h", t, own_data ? "data" : "inst",
                             wr ? "write" : "read", g_addr);
                end
                in_acc = (t > grant_at) && (t < hit_at);
                chk1($sformatf("rand t%0d ihit", t), ihit, (t == hit_at) && !own_data);
                chk1($sformatf("rand t%0d dhit", t), dhit, (t == hit_at) && own_data);
                chk1($sformatf("rand t%0d ren", t), sif.sram_ren, in_acc && !wr);
                chk1($sformatf("rand t%0d wen", t), sif.sram_wen, in_acc && wr);
                chk32($sformatf("rand t%0d iload", t), iload, exp_il);
                chk32($sformatf("rand t%0d dload", t), dload, exp_dl);
                if (in_acc) chk32($sformatf("rand t%0d addr", t), sif.sram_address, g_addr);
                if (in_acc && wr) chk32($sformatf("rand t%0d wdata", t), sif.sram_w_data, g_wdata);
                if (t >= free_at && (iren || dren || dwen)) begin
                    own_data  = (dren || dwen) && (!iren || !last_data);
                    last_data = own_data;
                    wr        = own_data && dwen;
                    g_addr    = own_data ? daddr : iaddr;
                    g_wdata   = dstore;
                    grant_at  = t;
                    hit_at    = t + LAT + 1;
                    free_at   = t + LAT + 2;
                    if (wr) begin
                        mmem[widx(g_addr)]    = g_wdata;
                        mmem_wr[widx(g_addr)] = 1'b1;
                    end else begin
                        pend_load = model_read(g_addr);
                    end
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
